// File: rtl/md_pkg.sv
// md_pkg: op/state encodings and default iteration count for the multiply/divide unit
package md_pkg;
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;
  localparam int MD_ITER_DEF = 32;
endpackage

// File: rtl/md_if.sv
// md_if: operand/result bundle between decode/register file and md_unit
interface md_if;
  import md_pkg::*;
  logic        start;
  md_op_t      op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_wen;
  logic        lo_wen;
  logic [31:0] hilo_data;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (
    output start, op, src_a, src_b, hi_wen, lo_wen, hilo_data,
    input  busy, done, div_by_zero, hi, lo
  );
  modport slave (
    input  start, op, src_a, src_b, hi_wen, lo_wen, hilo_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/md_iter_core.sv
// md_iter_core: 64-bit working register with one unsigned shift-add / restoring shift-subtract step
module md_iter_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [63:0] init,
  input  logic [31:0] opb,
  output logic [63:0] acc
);
  logic [31:0] b_q;
  logic [32:0] sum;
  logic [33:0] diff;
  logic [63:0] nxt;
  // Multiply: {partial product, multiplier} shifts right; divide: {remainder, dividend} shifts left
  always_comb begin
    sum  = {1'b0, acc[63:32]} + {1'b0, b_q};
    diff = {1'b0, acc[63:31]} - {2'b0, b_q};
    nxt  = is_div ? (diff[33] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1})
                  : (acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      b_q <= '0;
    end else if (load) begin
      acc <= init;
      b_q <= opb;
    end else if (step) begin
      acc <= nxt;
    end
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO writes
// MD_FAST_MUL_EN: single-cycle multiply that skips CALC; divide stays iterative
module md_unit
  import md_pkg::*;
#(
  parameter int MD_ITER = MD_ITER_DEF
) (
  input logic clk,
  input logic rst,
  md_if.slave bus
);
  localparam int CW = $clog2(MD_ITER);
  md_state_t   state;
  logic [CW-1:0] cnt;
  logic        is_div_q, neg_q, rem_neg_q, dz_q;
  logic [31:0] a_q;
  logic        go, div_op, sa, sb, fast;
  logic [31:0] mag_a, mag_b, quo, rem;
  logic [63:0] init, acc, prod;
  always_comb begin
    go     = state == MD_IDLE && bus.start;
    div_op = bus.op inside {MD_DIV, MD_DIVU};
    sa     = bus.op inside {MD_MULT, MD_DIV} && bus.src_a[31];
    sb     = bus.op inside {MD_MULT, MD_DIV} && bus.src_b[31];
    mag_a  = sa ? -bus.src_a : bus.src_a;
    mag_b  = sb ? -bus.src_b : bus.src_b;
`ifdef MD_FAST_MUL_EN
    fast   = !div_op;
    init   = fast ? {32'b0, mag_a} * {32'b0, mag_b} : {32'b0, mag_a};
`else
    fast   = 1'b0;
    init   = {32'b0, mag_a};
`endif
    prod   = neg_q ? -acc : acc;
    quo    = neg_q ? -acc[31:0] : acc[31:0];
    rem    = rem_neg_q ? -acc[63:32] : acc[63:32];
  end
  md_iter_core core (
    .clk   (clk),
    .rst   (rst),
    .load  (go),
    .step  (state == MD_CALC),
    .is_div(is_div_q),
    .init  (init),
    .opb   (mag_b),
    .acc   (acc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= MD_IDLE;
      cnt             <= '0;
      is_div_q        <= 1'b0;
      neg_q           <= 1'b0;
      rem_neg_q       <= 1'b0;
      dz_q            <= 1'b0;
      a_q             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
    end else begin
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (bus.hi_wen) bus.hi <= bus.hilo_data;
          if (bus.lo_wen) bus.lo <= bus.hilo_data;
          if (bus.start) begin
            is_div_q  <= div_op;
            neg_q     <= sa ^ sb;
            rem_neg_q <= sa;
            dz_q      <= div_op && bus.src_b == 32'd0;
            a_q       <= bus.src_a;
            cnt       <= '0;
            bus.busy  <= 1'b1;
            state     <= fast ? MD_FIX : MD_CALC;
          end
        end
        MD_CALC: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(MD_ITER - 1)) state <= MD_FIX;
        end
        MD_FIX: begin
          // Divide by zero reports the raw dividend rather than the iterated remainder
          bus.hi          <= dz_q ? a_q : is_div_q ? rem : prod[63:32];
          bus.lo          <= dz_q ? 32'hFFFF_FFFF : is_div_q ? quo : prod[31:0];
          bus.done        <= 1'b1;
          bus.div_by_zero <= dz_q;
          bus.busy        <= 1'b0;
          state           <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end
endmodule
